// File: rtl/instr_fetch_sequencer.sv
// Fetch/issue/update sequencer: fetches one word per instruction, decodes the
// branch class, holds it for execute, then takes the branch unit's next PC.
module instr_fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc_cur,
    output logic [1:0]  branch_control_signal,
    output logic [5:0]  ins_func_code,
    output logic [31:0] dest_addr,
    input  logic [31:0] next_pc,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        halted
);

    typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_UPDATE, S_HALT} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  ctrl;
        logic [5:0]  func;
        logic [31:0] dest;
    } dec_t;

    localparam dec_t DEC_RST = '{instr: 32'd0, ctrl: 2'b11, func: 6'd0, dest: 32'd0};

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d.instr = w;
        case (w[31:26])
            6'b000101: d.ctrl = 2'b00;
            6'b000110: d.ctrl = 2'b01;
            6'b000111: d.ctrl = 2'b10;
            default:   d.ctrl = 2'b11;
        endcase
        d.func = w[5:0];
        d.dest = {12'b0, w[25:6]};
        return d;
    endfunction

    state_t      state_q, state_d;
    dec_t        dec_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Decoded fields are registered at fetch so execute sees stable values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            dec_q <= DEC_RST;
        end else begin
            if (state_q == S_FETCH && imem_ack) dec_q <= decode(imem_rdata);
            if (state_q == S_UPDATE)            pc_q  <= next_pc;
        end
    end

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        link_we     = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)
                    state_d = (imem_rdata[31:26] == HALT_OPCODE) ? S_HALT : S_ISSUE;
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                link_we = (dec_q.ctrl == 2'b10);
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign imem_addr             = pc_q;
    assign pc_cur                = pc_q;
    assign instr                 = dec_q.instr;
    assign branch_control_signal = dec_q.ctrl;
    assign ins_func_code         = dec_q.func;
    assign dest_addr             = dec_q.dest;
    assign link_data             = pc_q + 32'd1;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench: stimulus pushes expected fetches/issues/link writes into
// queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_instr_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] pc_cur;
    logic [1:0]  branch_control_signal;
    logic [5:0]  ins_func_code;
    logic [31:0] dest_addr;
    logic [31:0] next_pc = 32'd0;
    logic        link_we;
    logic [31:0] link_data;
    logic        halted;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  ctrl;
        logic [5:0]  func;
        logic [31:0] dest;
    } iss_t;

    logic [31:0] fetch_q[$];
    iss_t        issue_q[$];
    logic [31:0] link_q[$];

    int checks = 0;
    int errors = 0;

    instr_fetch_sequencer #(.RESET_PC(32'd0), .HALT_OPCODE(6'b111111)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_cur(pc_cur), .branch_control_signal(branch_control_signal),
        .ins_func_code(ins_func_code), .dest_addr(dest_addr),
        .next_pc(next_pc), .link_we(link_we), .link_data(link_data),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares each observable transaction against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_ack) begin
                if (fetch_q.size() == 0) chk("unexpected_fetch", imem_addr, 32'hDEAD_BEEF);
                else chk("fetch_addr", imem_addr, fetch_q.pop_front());
            end
            if (instr_valid && instr_ready) begin
                if (issue_q.size() == 0) chk("unexpected_issue", instr, 32'hDEAD_BEEF);
                else begin
                    iss_t e;
                    e = issue_q.pop_front();
                    chk("issue_instr", instr, e.instr);
                    chk("issue_pc", pc_cur, e.pc);
                    chk("issue_ctrl", {30'd0, branch_control_signal}, {30'd0, e.ctrl});
                    chk("issue_func", {26'd0, ins_func_code}, {26'd0, e.func});
                    chk("issue_dest", dest_addr, e.dest);
                end
            end
            if (link_we) begin
                if (link_q.size() == 0) chk("unexpected_link", link_data, 32'hDEAD_BEEF);
                else chk("link_data", link_data, link_q.pop_front());
            end
        end
    end

    // Waits (bounded) for a fetch, holds ack off for dly cycles, then acks once.
    task automatic fetch_ack(input logic [31:0] rd, input int dly);
        int n;
        logic [31:0] a0;
        n = 0;
        while (!imem_req && n < 50) begin tick(); n++; end
        if (!imem_req) chk("fetch_wait_timeout", {31'd0, imem_req}, 32'd1);
        a0 = imem_addr;
        for (int i = 0; i < dly; i++) begin
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_stable", imem_addr, a0);
            tick();
        end
        imem_ack = 1'b1;
        imem_rdata = rd;
        tick();
        imem_ack = 1'b0;
        imem_rdata = 32'hA5A5_A5A5;
    endtask

    // In S_ISSUE: hold ready low dly cycles, then accept; returns in S_UPDATE.
    task automatic issue(input int dly, input logic [31:0] npc);
        logic [31:0] i0;
        chk("issue_valid", {31'd0, instr_valid}, 32'd1);
        next_pc = npc;
        i0 = instr;
        for (int i = 0; i < dly; i++) begin
            chk("valid_held", {31'd0, instr_valid}, 32'd1);
            chk("no_refetch", {31'd0, imem_req}, 32'd0);
            chk("instr_stable", instr, i0);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic push_iss(input logic [31:0] i, input logic [31:0] pc,
                            input logic [1:0] c, input logic [5:0] f, input logic [31:0] d);
        iss_t e;
        e.instr = i; e.pc = pc; e.ctrl = c; e.func = f; e.dest = d;
        issue_q.push_back(e);
    endtask

    initial begin
        // Reset values (rst still high after two edges)
        tick(); tick();
        chk("rst_pc", pc_cur, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ctrl", {30'd0, branch_control_signal}, 32'd3);
        chk("rst_func", {26'd0, ins_func_code}, 32'd0);
        chk("rst_dest", dest_addr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_link_we", {31'd0, link_we}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // Back-to-back minimum latency: fetch, issue, update, fetch again
        fetch_q.push_back(32'd0);
        push_iss(32'd0, 32'd0, 2'b11, 6'd0, 32'd0);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'd0; instr_ready = 1'b1; next_pc = 32'd1;
        chk("lat_c0_req", {31'd0, imem_req}, 32'd1);
        chk("lat_c0_addr", imem_addr, 32'd0);
        tick();
        chk("lat_c1_valid", {31'd0, instr_valid}, 32'd1);
        chk("lat_c1_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("lat_c2_valid", {31'd0, instr_valid}, 32'd0);
        chk("lat_c2_req", {31'd0, imem_req}, 32'd0);
        chk("lat_c2_link", {31'd0, link_we}, 32'd0);
        tick();
        imem_ack = 1'b0; instr_ready = 1'b0;
        chk("lat_c3_req", {31'd0, imem_req}, 32'd1);
        chk("lat_c3_addr", imem_addr, 32'd1);

        // Plain instruction at pc 1
        fetch_q.push_back(32'd1);
        push_iss(32'd0, 32'd1, 2'b11, 6'd0, 32'd0);
        fetch_ack(32'd0, 0);
        issue(0, 32'd2);
        tick();

        // Linking branch at pc 2 -> target 5, link 3
        fetch_q.push_back(32'd2);
        push_iss(32'h1C00_0140, 32'd2, 2'b10, 6'd0, 32'd5);
        link_q.push_back(32'd3);
        fetch_ack(32'h1C00_0140, 0);
        issue(0, 32'd5);
        chk("jal_link_we", {31'd0, link_we}, 32'd1);
        chk("jal_link_data", link_data, 32'd3);
        tick();
        chk("jal_next_addr", imem_addr, 32'd5);
        chk("jal_link_we_off", {31'd0, link_we}, 32'd0);

        // Execute stall 4 cycles at pc 5
        fetch_q.push_back(32'd5);
        push_iss(32'h1400_0042, 32'd5, 2'b00, 6'b000010, 32'd1);
        fetch_ack(32'h1400_0042, 0);
        issue(4, 32'd6);
        chk("stall_no_link", {31'd0, link_we}, 32'd0);
        tick();

        // Memory ack delayed 5 cycles at pc 6; next_pc at top of address space
        fetch_q.push_back(32'd6);
        push_iss(32'h1800_0003, 32'd6, 2'b01, 6'd3, 32'd0);
        fetch_ack(32'h1800_0003, 5);
        issue(0, 32'hFFFF_FFFF);
        tick();

        // Linking branch at pc FFFFFFFF: return address wraps to 0
        fetch_q.push_back(32'hFFFF_FFFF);
        push_iss(32'h1C00_0000, 32'hFFFF_FFFF, 2'b10, 6'd0, 32'd0);
        link_q.push_back(32'd0);
        fetch_ack(32'h1C00_0000, 0);
        issue(0, 32'd9);
        chk("wrap_link_data", link_data, 32'd0);
        tick();
        chk("wrap_next_addr", imem_addr, 32'd9);

        // Reset arriving with instr_ready in S_ISSUE discards the handshake
        fetch_q.push_back(32'd9);
        fetch_ack(32'h1C00_0040, 0);
        chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        next_pc = 32'd7; instr_ready = 1'b1; rst = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("midrst_link_we", {31'd0, link_we}, 32'd0);
        chk("midrst_pc", pc_cur, 32'd0);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_req", {31'd0, imem_req}, 32'd1);
        chk("midrst_ctrl", {30'd0, branch_control_signal}, 32'd3);
        tick();
        rst = 1'b0;

        // Halt opcode: never issued, fetching stops, only reset recovers
        fetch_q.push_back(32'd0);
        fetch_ack(32'hFC00_0000, 0);
        imem_ack = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("halt_flag", {31'd0, halted}, 32'd1);
            chk("halt_no_req", {31'd0, imem_req}, 32'd0);
            chk("halt_no_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt_no_link", {31'd0, link_we}, 32'd0);
            tick();
        end
        imem_ack = 1'b0; instr_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("unhalt_flag", {31'd0, halted}, 32'd0);
        chk("unhalt_pc", pc_cur, 32'd0);
        chk("unhalt_req", {31'd0, imem_req}, 32'd1);
        tick();

        chk("fetch_q_drained", fetch_q.size(), 32'd0);
        chk("issue_q_drained", issue_q.size(), 32'd0);
        chk("link_q_drained", link_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
